framebuffer_pixel_writer: RTL

- Receiving end of the raytracer pixel stream: accepts one-cycle (valid, x, y, value) pixel strobes and writes them into the framebuffer BRAM write port.
- The BRAM port may stall, so pixels are buffered in a small FIFO. The pixel source has no backpressure.
- Tracks frame progress, reports frame completion, and flags dropped or out-of-range pixels.

---
 rtl/framebuffer_pixel_writer_pkg.sv | 18 +
 rtl/framebuffer_pixel_writer_if.sv | 10 +
 rtl/framebuffer_pixel_writer_fifo.sv | 52 +++++
 rtl/framebuffer_pixel_writer.sv | 104 ++++++++++
 4 files changed

// File: rtl/framebuffer_pixel_writer_pkg.sv
// Shared types for the framebuffer pixel writer: screen coordinates, framebuffer
// addresses, the queued pixel-write record and the writer FSM states.
package framebuffer_pixel_writer_pkg;
    localparam int SCREEN_WIDTH  = 320;
    localparam int SCREEN_HEIGHT = 180;
    localparam int ADDR_W        = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT);

    typedef logic [$clog2(SCREEN_WIDTH)-1:0]  ScreenX;
    typedef logic [$clog2(SCREEN_HEIGHT)-1:0] ScreenY;
    typedef logic [ADDR_W-1:0]                FbAddr;

    typedef struct packed {
        FbAddr       addr;
        logic [15:0] value;
    } PixelWrite;

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} fb_state_e;
endpackage

// File: rtl/framebuffer_pixel_writer_if.sv
// Framebuffer BRAM write port: the writer is master, the BRAM side is slave.
interface framebuffer_pixel_writer_if #(parameter int AW = 16);
    logic          fb_wr_en;
    logic [AW-1:0] fb_wr_addr;
    logic [15:0]   fb_wr_data;
    logic          fb_wr_ready;

    modport master (output fb_wr_en, fb_wr_addr, fb_wr_data, input fb_wr_ready);
    modport slave  (input fb_wr_en, fb_wr_addr, fb_wr_data, output fb_wr_ready);
endinterface

// File: rtl/framebuffer_pixel_writer_fifo.sv
// pixel_fifo: synchronous FIFO of PixelWrite with flush; a push on a full FIFO
// succeeds when a pop happens in the same cycle.
module pixel_fifo
    import framebuffer_pixel_writer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    input  logic      push,
    input  PixelWrite push_data,
    input  logic      pop,
    output PixelWrite head,
    output logic      full,
    output logic      empty
);
    localparam int PW = $clog2(DEPTH);

    PixelWrite      mem [DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [PW:0]    count;
    logic           push_ok, pop_ok;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            // A flush may coincide with the first push of the next frame
            rd_ptr <= '0;
            wr_ptr <= PW'(push);
            count  <= {{PW{1'b0}}, push};
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop_ok};
        end
    end

    always_ff @(posedge clk) begin
        if (flush && push)  mem[0]      <= push_data;
        else if (!flush && push_ok) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/framebuffer_pixel_writer.sv
// Accepts raytracer pixel strobes, queues them and writes them to the framebuffer.
// Optional DOUBLE_BUFFER_EN: writes go to the back bank, banks swap on frame completion.
module framebuffer_pixel_writer
    import framebuffer_pixel_writer_pkg::*;
#(
    parameter int SCREEN_WIDTH  = framebuffer_pixel_writer_pkg::SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = framebuffer_pixel_writer_pkg::SCREEN_HEIGHT,
    parameter int FIFO_DEPTH    = 4,
    parameter int ADDR_W        = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  pixel_valid_in,
    input  ScreenX                pixel_x_in,
    input  ScreenY                pixel_y_in,
    input  logic [15:0]           pixel_value_in,
    framebuffer_pixel_writer_if.master fb,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overflow,
    output logic                  range_err,
    output logic [ADDR_W:0]       pixels_written,
    output logic                  display_bank
);
    localparam int TOTAL = SCREEN_WIDTH * SCREEN_HEIGHT;

    fb_state_e   state, state_d;
    logic        done_hit, accept, in_range, push, pop, full, empty;
    logic [ADDR_W-1:0] pix_addr;
    PixelWrite   head;

    assign in_range = (int'(pixel_x_in) < SCREEN_WIDTH) && (int'(pixel_y_in) < SCREEN_HEIGHT);
    assign accept   = pixel_valid_in && (frame_start || state == ACTIVE);
    assign push     = accept && in_range;
    assign pix_addr = ADDR_W'(pixel_y_in) * ADDR_W'(SCREEN_WIDTH) + ADDR_W'(pixel_x_in);
    assign pop      = fb.fb_wr_en && fb.fb_wr_ready;

    pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (frame_start),
        .push      (push),
        .push_data ('{addr: FbAddr'(pix_addr), value: pixel_value_in}),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    // The FIFO head register is the write port, so a fresh pixel shows next cycle
    assign fb.fb_wr_en   = !empty;
    assign fb.fb_wr_data = fb.fb_wr_en ? head.value : 16'h0;
`ifdef DOUBLE_BUFFER_EN
    assign fb.fb_wr_addr = fb.fb_wr_en ? {~display_bank, head.addr[ADDR_W-1:0]} : '0;
`else
    assign fb.fb_wr_addr = fb.fb_wr_en ? head.addr[ADDR_W-1:0] : '0;
`endif

    assign busy = (state == ACTIVE) || !empty;

    always_comb begin
        state_d  = state;
        done_hit = 1'b0;
        if (frame_start) begin
            state_d = ACTIVE;
        end else if (state == ACTIVE && pixels_written == (ADDR_W+1)'(TOTAL) && empty && !push) begin
            state_d  = DONE;
            done_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            frame_done     <= 1'b0;
            overflow       <= 1'b0;
            range_err      <= 1'b0;
            pixels_written <= '0;
        end else begin
            state      <= state_d;
            frame_done <= done_hit;
            if (frame_start) begin
                overflow       <= 1'b0;
                range_err      <= accept && !in_range;
                pixels_written <= '0;
            end else begin
                if (push && full && !pop) overflow  <= 1'b1;
                if (accept && !in_range)  range_err <= 1'b1;
                if (pop && pixels_written != (ADDR_W+1)'(TOTAL))
                    pixels_written <= pixels_written + 1'b1;
            end
        end
    end

`ifdef DOUBLE_BUFFER_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           display_bank <= 1'b0;
        else if (done_hit) display_bank <= ~display_bank;
    end
`else
    assign display_bank = 1'b0;
`endif
endmodule
